lsu_stage: RTL

//  Memory stage of the RV32I core, directly downstream of the ALU. Takes the ALU result as

---
 rtl/lsu_stage.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_stage.sv
// lsu_stage -- memory stage of the RV32I core.
//
// Takes the ALU result as effective address (LOAD/STORE) or as writeback value
// (everything else). It runs one req/ack data-memory transaction, aligns store
// data and strobes, and extracts and extends load data. It then hands one
// writeback record per instruction to WB over a valid/ready handshake. Only one
// instruction is in flight at a time.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   in_valid / in_ready       instruction handshake from EX (ready only in IDLE)
//   opcode, funct3            RV32I opcode and width/sign select
//   alu_out                   address (LOAD/STORE) or writeback value
//   rs2_data, rd              store source data, destination register
//   mem_req/we/addr/wdata/wstrb   data-memory request, held until mem_ack
//   mem_ack, mem_rdata        memory completion and read word
//   out_valid / out_ready     writeback record handshake to WB
//   wb_data, wb_rd, wb_en     writeback record
//   fault                     misaligned / illegal width / timeout (wb_en forced 0)
module lsu_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_en,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_en_q, wb_en_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_load_q, is_load_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic [1:0]    off_q, off_d;

  logic is_load, is_store, is_branch, mem_op;
  logic ld_legal, st_legal, aligned, mem_ok;

  // Byte/half/word extraction from the raw read word.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_extend = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_extend = {24'd0, lane[7:0]};
      3'b101:  load_extend = {16'd0, lane[15:0]};
      default: load_extend = lane;
    endcase
  endfunction

  // Store data is replicated across all lanes; the strobes pick the live bytes.
  function automatic logic [31:0] store_data(input logic [31:0] src,
                                             input logic [1:0]  size);
    case (size)
      2'b00:   store_data = {4{src[7:0]}};
      2'b01:   store_data = {2{src[15:0]}};
      default: store_data = src;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size,
                                            input logic [1:0] off);
    case (size)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign mem_op    = is_load | is_store;

  assign ld_legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b101);
  assign st_legal = (funct3 < 3'b011);
  // funct3[1:0] carries the access size for every legal encoding.
  assign aligned  = (funct3[1:0] == 2'b00) |
                    ((funct3[1:0] == 2'b01) & ~alu_out[0]) |
                    ((funct3[1:0] == 2'b10) & (alu_out[1:0] == 2'b00));
  assign mem_ok   = mem_op & aligned & (is_load ? ld_legal : st_legal);

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_en_d     = wb_en_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    ld_f3_d     = ld_f3_q;
    off_d       = off_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wb_rd_d   = rd;
          wb_data_d = alu_out;
          is_load_d = is_load;
          ld_f3_d   = funct3;
          off_d     = alu_out[1:0];
          if (mem_ok) begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_we_d    = is_store;
            mem_addr_d  = {alu_out[31:2], 2'b00};
            mem_wdata_d = store_data(rs2_data, funct3[1:0]);
            mem_wstrb_d = is_store ? store_strb(funct3[1:0], alu_out[1:0]) : 4'b0000;
            fault_d     = 1'b0;
            wb_en_d     = is_load & (rd != 5'd0);
          end else begin
            // Any memory op reaching here is misaligned or has an illegal width.
            state_d = S_RESP;
            fault_d = mem_op;
            wb_en_d = ~mem_op & ~is_branch & (rd != 5'd0);
          end
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle still completes the access.
        if (mem_ack) begin
          state_d = S_RESP;
          if (is_load_q) wb_data_d = load_extend(mem_rdata, off_q, ld_f3_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          fault_d = 1'b1;
          wb_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_en_q     <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      ld_f3_q     <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_en_q     <= wb_en_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      ld_f3_q     <= ld_f3_d;
      off_q       <= off_d;
    end
  end

  // Handshake outputs decode straight from state, so reset drops them at once.
  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign out_valid = (state_q == S_RESP);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_en     = wb_en_q;
  assign fault     = fault_q;

endmodule
